// File: rtl/yolo_fp_pkg.sv
// Shared fp32 helpers for the YOLO pooling layers: word type and the
// sign-magnitude maximum used by every max-pool stage.
package yolo_fp_pkg;

  localparam int FP32_WIDTH = 32;

  typedef logic [FP32_WIDTH-1:0] fp32_t;

  // Sign-magnitude maximum. Ties (including +0 vs -0) return the first
  // operand. NaN/Inf are ordered purely by bit pattern.
  function automatic fp32_t fp32_max(input fp32_t a, input fp32_t b);
    fp32_t      res;
    logic [30:0] a_mag;
    logic [30:0] b_mag;
    a_mag = a[30:0];
    b_mag = b[30:0];
    res   = a;
    if ((a_mag == '0) && (b_mag == '0)) begin
      res = a;
    end else if (a[31] != b[31]) begin
      res = a[31] ? b : a;
    end else if (!a[31]) begin
      res = (b_mag > a_mag) ? b : a;
    end else begin
      res = (b_mag < a_mag) ? b : a;
    end
    return res;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// Line buffer holding one row of horizontal pair maxima between the even
// and odd input rows: synchronous write, combinational read.
module maxpool_line_buffer #(
  parameter int DEPTH = 52,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_4_maxpool2x2.sv
// Stride-2 2x2 max pool over a raster fp32 pixel stream, one register stage.
// Optional macro MAXPOOL_RELU_EN clamps negative pooled results to +0.
module layer_4_maxpool2x2
  import yolo_fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = $clog2(IMG_SIZE);
  localparam int AW   = CW - 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  generate
    if ((IMG_SIZE % 2) != 0 || IMG_SIZE < 4) begin : g_bad_size
      $error("layer_4_maxpool2x2: IMG_SIZE must be even and >= 4");
    end
    if (DATA_WIDTH != FP32_WIDTH) begin : g_bad_width
      $error("layer_4_maxpool2x2: only DATA_WIDTH = 32 is supported");
    end
  endgenerate

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  fp32_t         h_reg_q, h_reg_d;
  fp32_t         data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          frame_done_q, frame_done_d;

  fp32_t         h_max_c;
  fp32_t         pooled_c;
  fp32_t         pooled_clamped_c;
  fp32_t         lb_rdata;
  logic          lb_we;
  logic [AW-1:0] lb_addr;
  logic          col_odd;
  logic          row_odd;
  logic          out_fire;

  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign lb_addr  = col_q[CW-1:1];
  assign h_max_c  = fp32_max(h_reg_q, data_in);
  assign pooled_c = fp32_max(lb_rdata, h_max_c);
  assign lb_we    = valid_in & col_odd & ~row_odd;
  assign out_fire = valid_in & col_odd & row_odd;

`ifdef MAXPOOL_RELU_EN
  assign pooled_clamped_c = pooled_c[31] ? '0 : pooled_c;
`else
  assign pooled_clamped_c = pooled_c;
`endif

  // Same index is written on the even row and read on the next odd row.
  maxpool_line_buffer #(
    .DEPTH (HALF),
    .WIDTH (FP32_WIDTH),
    .AW    (AW)
  ) u_line_buffer (
    .clk_i   (Clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (h_max_c),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    h_reg_d      = h_reg_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (valid_in) begin
      if (!col_odd) begin
        h_reg_d = data_in;
      end
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (out_fire) begin
      data_out_d   = pooled_clamped_c;
      valid_out_d  = 1'b1;
      frame_done_d = (col_q == LAST) && (row_q == LAST);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q        <= '0;
      row_q        <= '0;
      h_reg_q      <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      h_reg_q      <= h_reg_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_layer_4_maxpool2x2.sv
// Bench for layer_4_maxpool2x2 at IMG_SIZE=4: directed windows plus random
// frames, checked cycle by cycle against a flat-frame max-pool model.
module tb_layer_4_maxpool2x2;

  localparam int IMG  = 4;
  localparam int NPIX = IMG * IMG;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  layer_4_maxpool2x2 #(
    .DATA_WIDTH (32),
    .IMG_SIZE   (IMG)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  // ---------------- reference model ----------------
  // Ordering key: signed value of the sign-magnitude number, both zeros map to 0.
  function automatic longint fkey(input logic [31:0] v);
    if (v[30:0] == 31'd0) return 0;
    return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
  endfunction

  // Window in arrival order; the earliest of the maximal keys wins.
  function automatic logic [31:0] pool4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    logic [31:0] w [4];
    logic [31:0] best;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    best = w[0];
    for (int i = 1; i < 4; i++) if (fkey(w[i]) > fkey(best)) best = w[i];
`ifdef MAXPOOL_RELU_EN
    if (best[31]) best = 32'h0;
`endif
    return best;
  endfunction

  logic [31:0] pix [NPIX];
  int          pidx;
  logic        m_valid;
  logic        m_done;
  logic [31:0] m_data;
  logic [31:0] exp_q [$];

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pidx    <= 0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_data  <= 32'h0;
      exp_q.delete();
    end else begin
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      if (valid_in) begin
        pix[pidx] <= data_in;
        if (((pidx / IMG) % 2 == 1) && ((pidx % IMG) % 2 == 1)) begin
          m_valid <= 1'b1;
          m_done  <= (pidx == NPIX - 1);
          m_data  <= pool4(pix[pidx-IMG-1], pix[pidx-IMG], pix[pidx-1], data_in);
          exp_q.push_back(pool4(pix[pidx-IMG-1], pix[pidx-IMG], pix[pidx-1], data_in));
        end
        pidx <= (pidx == NPIX - 1) ? 0 : pidx + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_w(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  logic [31:0] got_q [$];
  int          done_cnt;

  always @(negedge Clk) begin
    check_i("valid_out", int'(valid_out), int'(m_valid));
    check_i("frame_done", int'(frame_done), int'(m_done));
    check_w("data_out", data_out, m_data);
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      if (exp_q.size() > 0) check_w("pulse_order", data_out, exp_q.pop_front());
      else check_w("pulse_unexpected", data_out, 32'hxxxxxxxx);
    end
    if (frame_done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  logic [31:0] fnum [17];

  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge Clk);
    valid_in = v;
    data_in  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  task automatic do_reset(input int n);
    @(negedge Clk);
    valid_in = 1'b0;
    Rst      = 1'b0;
    repeat (n) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic clear_log();
    got_q.delete();
    done_cnt = 0;
  endtask

  function automatic logic [31:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF;
  endfunction

  task automatic send_frame_seq(input logic rev, input logic toggle);
    for (int i = 1; i <= NPIX; i++) begin
      drive(1'b1, rev ? fnum[NPIX + 1 - i] : fnum[i]);
      if (toggle) drive(1'b0, $urandom);
    end
  endtask

  task automatic send_window(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
    for (int i = 0; i < NPIX; i++) begin
      case (i)
        0:       drive(1'b1, a);
        1:       drive(1'b1, b);
        IMG:     drive(1'b1, c);
        IMG + 1: drive(1'b1, d);
        default: drive(1'b1, fnum[i + 1]);
      endcase
    end
  endtask

  function automatic logic [31:0] rand_pix();
    logic [31:0] pool [8];
    pool[0] = 32'h00000000; pool[1] = 32'h80000000; pool[2] = 32'h3F800000;
    pool[3] = 32'hBF800000; pool[4] = 32'h7F800000; pool[5] = 32'hFF800000;
    pool[6] = 32'h7FC00000; pool[7] = 32'h40000000;
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i <= 16; i++) fnum[i] = 32'h0;
    fnum[1]  = 32'h3F800000; fnum[2]  = 32'h40000000; fnum[3]  = 32'h40400000;
    fnum[4]  = 32'h40800000; fnum[5]  = 32'h40A00000; fnum[6]  = 32'h40C00000;
    fnum[7]  = 32'h40E00000; fnum[8]  = 32'h41000000; fnum[9]  = 32'h41100000;
    fnum[10] = 32'h41200000; fnum[11] = 32'h41300000; fnum[12] = 32'h41400000;
    fnum[13] = 32'h41500000; fnum[14] = 32'h41600000; fnum[15] = 32'h41700000;
    fnum[16] = 32'h41800000;

    Rst      = 1'b0;
    valid_in = 1'b0;
    data_in  = 32'h0;
    done_cnt = 0;
    repeat (3) @(negedge Clk);
    check_w("reset data_out", data_out, 32'h0);
    check_i("reset valid_out", int'(valid_out), 0);
    check_i("reset frame_done", int'(frame_done), 0);
    Rst = 1'b1;
    idle(2);

    // 1..16 with valid always high
    clear_log();
    send_frame_seq(1'b0, 1'b0);
    idle(3);
    check_i("t1 pulses", got_q.size(), 4);
    check_w("t1 out0", got_at(0), 32'h40C00000);
    check_w("t1 out1", got_at(1), 32'h41000000);
    check_w("t1 out2", got_at(2), 32'h41600000);
    check_w("t1 out3", got_at(3), 32'h41800000);
    check_i("t1 frame_done", done_cnt, 1);

    // all-negative window
    clear_log();
    send_window(32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0A00000);
    idle(3);
`ifdef MAXPOOL_RELU_EN
    check_w("t2 neg window", got_at(0), 32'h00000000);
`else
    check_w("t2 neg window", got_at(0), 32'hBF800000);
`endif

    // signed-zero tie keeps the first operand
    clear_log();
    send_window(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000);
    idle(3);
`ifdef MAXPOOL_RELU_EN
    check_w("t3 zero tie", got_at(0), 32'h00000000);
`else
    check_w("t3 zero tie", got_at(0), 32'h80000000);
`endif

    // valid toggled every cycle
    clear_log();
    send_frame_seq(1'b0, 1'b1);
    idle(3);
    check_i("t4 pulses", got_q.size(), 4);
    check_w("t4 out0", got_at(0), 32'h40C00000);
    check_w("t4 out3", got_at(3), 32'h41800000);

    // reset after 9 pixels, then a clean frame
    for (int i = 1; i <= 9; i++) drive(1'b1, fnum[i]);
    do_reset(2);
    clear_log();
    send_frame_seq(1'b0, 1'b0);
    idle(3);
    check_i("t5 pulses", got_q.size(), 4);
    check_w("t5 out0", got_at(0), 32'h40C00000);
    check_w("t5 out3", got_at(3), 32'h41800000);
    check_i("t5 frame_done", done_cnt, 1);

    // back-to-back frames, second reversed
    clear_log();
    send_frame_seq(1'b0, 1'b0);
    send_frame_seq(1'b1, 1'b0);
    idle(3);
    check_i("t6 pulses", got_q.size(), 8);
    check_i("t6 frame_done", done_cnt, 2);
    check_w("t6 out4", got_at(4), 32'h41800000);
    check_w("t6 out5", got_at(5), 32'h41600000);
    check_w("t6 out6", got_at(6), 32'h41000000);
    check_w("t6 out7", got_at(7), 32'h40C00000);

    // random frames with random gaps and one mid-frame reset
    clear_log();
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        while ($urandom_range(0, 9) < 3) drive(1'b0, $urandom);
        drive(1'b1, rand_pix());
        if (f == 12 && i == 6) begin
          do_reset(1);
          clear_log();
          break;
        end
      end
    end
    idle(4);
    check_i("rand frame_done", done_cnt, 17);
    check_i("rand exp_q drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
